// File: rtl/du_pkg.sv
// du_pkg: framing bytes, mode codes and sender state encoding shared by the debug-unit master, loader and sender.
// The CHK state exists only when DU_REGS_CHKSUM_EN is defined.
package du_pkg;

    localparam logic [7:0] ACK = 8'h05;
    localparam logic [7:0] NAK = 8'h15;
    localparam logic [7:0] SOT = 8'h01;
    localparam logic [7:0] EOT = 8'h04;

    localparam logic [7:0] CONT = 8'h01;
    localparam logic [7:0] STEP = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SOT   = 3'd1,
        S_RD    = 3'd2,
        S_LATCH = 3'd3,
        S_BYTE  = 3'd4,
`ifdef DU_REGS_CHKSUM_EN
        S_CHK   = 3'd5,
`endif
        S_EOT   = 3'd6,
        S_DONE  = 3'd7
    } sender_state_t;

endpackage

// File: rtl/du_byte_serializer.sv
// du_byte_serializer: holds one NB_WORD word and hands it out low byte first,
// advancing only when the consumer accepts the current byte (i_shift).
module du_byte_serializer #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [NB_WORD-1:0] i_word,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_last
);

    localparam int N_BYTES = NB_WORD / NB_BYTE;
    localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [NB_WORD-1:0] shreg;
    logic [NB_IDX-1:0]  byte_idx;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (i_clear) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (i_load) begin
            shreg    <= i_word;
            byte_idx <= '0;
        end else if (i_shift) begin
            shreg    <= shreg >> NB_BYTE;
            byte_idx <= byte_idx + NB_IDX'(1);
        end
    end

    assign o_byte = shreg[NB_BYTE-1:0];
    assign o_last = (byte_idx == NB_IDX'(N_BYTES - 1));

endmodule

// File: rtl/du_regs_sender.sv
// du_regs_sender: streams every register-file entry as SOT, little-endian data bytes, EOT into the UART Tx FIFO.
// Define DU_REGS_CHKSUM_EN to insert an XOR checksum byte of the data bytes just before EOT.
module du_regs_sender
    import du_pkg::*;
#(
    parameter int NB_REG       = 32,
    parameter int N_REGS       = 32,
    parameter int NB_ADDR      = 5,
    parameter int NB_UART_DATA = 8
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [NB_REG-1:0]       i_reg_data,
    input  logic                    i_tx_full,
    output logic [NB_ADDR-1:0]      o_reg_addr,
    output logic                    o_wr,
    output logic [NB_UART_DATA-1:0] o_wdata,
    output logic                    o_tx_start,
    output logic                    o_done
);

    sender_state_t           state;
    logic                    wr_state;
    logic                    abort;
    logic                    last_reg;
    logic                    ser_last;
    logic [NB_UART_DATA-1:0] ser_byte;
`ifdef DU_REGS_CHKSUM_EN
    logic [NB_UART_DATA-1:0] chksum;
`endif

    // Master leaving its send state mid-frame abandons the frame; DONE waits for the fall itself.
    assign abort    = !i_start && (state != S_IDLE) && (state != S_DONE);
    assign last_reg = (o_reg_addr == NB_ADDR'(N_REGS - 1));

    du_byte_serializer #(
        .NB_WORD (NB_REG),
        .NB_BYTE (NB_UART_DATA)
    ) u_serializer (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clear (abort || (state == S_IDLE)),
        .i_load  (state == S_LATCH),
        .i_shift ((state == S_BYTE) && !i_tx_full),
        .i_word  (i_reg_data),
        .o_byte  (ser_byte),
        .o_last  (ser_last)
    );

    always_comb begin
        wr_state = 1'b0;
        o_wdata  = '0;
        case (state)
            S_SOT: begin
                wr_state = 1'b1;
                o_wdata  = NB_UART_DATA'(SOT);
            end
            S_BYTE: begin
                wr_state = 1'b1;
                o_wdata  = ser_byte;
            end
`ifdef DU_REGS_CHKSUM_EN
            S_CHK: begin
                wr_state = 1'b1;
                o_wdata  = chksum;
            end
`endif
            S_EOT: begin
                wr_state = 1'b1;
                o_wdata  = NB_UART_DATA'(EOT);
            end
            default: ;
        endcase
    end

    assign o_wr       = wr_state && !i_tx_full;
    assign o_tx_start = o_wr;
    assign o_done     = (state == S_DONE);

    // Every write state holds until the FIFO has room, so a full cycle never loses or repeats a byte.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            o_reg_addr <= '0;
`ifdef DU_REGS_CHKSUM_EN
            chksum     <= '0;
`endif
        end else if (abort) begin
            state      <= S_IDLE;
            o_reg_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_reg_addr <= '0;
`ifdef DU_REGS_CHKSUM_EN
                    chksum     <= '0;
`endif
                    if (i_start) state <= S_SOT;
                end
                S_SOT: begin
                    if (!i_tx_full) begin
                        o_reg_addr <= '0;
                        state      <= S_RD;
                    end
                end
                S_RD:    state <= S_LATCH;
                S_LATCH: state <= S_BYTE;
                S_BYTE: begin
                    if (!i_tx_full) begin
`ifdef DU_REGS_CHKSUM_EN
                        chksum <= chksum ^ ser_byte;
`endif
                        if (ser_last) begin
                            if (last_reg) begin
`ifdef DU_REGS_CHKSUM_EN
                                state <= S_CHK;
`else
                                state <= S_EOT;
`endif
                            end else begin
                                o_reg_addr <= o_reg_addr + NB_ADDR'(1);
                                state      <= S_RD;
                            end
                        end
                    end
                end
`ifdef DU_REGS_CHKSUM_EN
                S_CHK: begin
                    if (!i_tx_full) state <= S_EOT;
                end
`endif
                S_EOT: begin
                    if (!i_tx_full) state <= S_DONE;
                end
                S_DONE: begin
                    if (!i_start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/du_regs_sender.md
Name: du_regs_sender

Overview:
- Responder side of the debug-unit "send registers" handshake.
- Started by the master's send-regs-start level. Reads every CPU register-file entry through a debug read port, serialises it into framed bytes, and pushes them into the UART Tx FIFO.
- Raises done when the frame is fully queued.
- Sits between the debug master, the register-file debug port and the UART Tx FIFO.

Parameters:
- NB_REG, 32, width of one register in bits; must be a multiple of NB_UART_DATA.
- N_REGS, 32, number of registers sent.
- NB_ADDR, 5, register address width; 2^NB_ADDR >= N_REGS.
- NB_UART_DATA, 8, UART byte width.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  level from master; held high while master is in its send-registers state.
- i_reg_data  in  NB_REG  register-file debug read data, valid one cycle after o_reg_addr.
- i_tx_full  in  1  UART Tx FIFO full.
- o_reg_addr  out  NB_ADDR  register-file debug read address.
- o_wr  out  1  UART Tx FIFO write enable, one byte per asserted cycle.
- o_wdata  out  NB_UART_DATA  byte written when o_wr=1.
- o_tx_start  out  1  asserted in exactly the cycles o_wr=1.
- o_done  out  1  frame fully queued; held until i_start falls.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_wr=0, o_tx_start=0, o_wdata=0x00, o_reg_addr=0, o_done=0; reg index, byte index and checksum cleared. Reset mid-frame abandons the frame; no partial bytes after release.
- Outputs o_wr, o_wdata and o_tx_start are decoded from registered state. The write condition is qualified by a combinational !i_tx_full.
- Frame: SOT 0x01, then N_REGS×(NB_REG/8) data bytes, then EOT 0x04.
  - Register order: 0..N_REGS-1.
  - Byte order per register: little-endian (bits 7:0 first).
  - With defaults: 130 bytes.
- States:
  - IDLE: o_done=0. On i_start=1 go to SOT.
  - SOT: when !i_tx_full, write 0x01, set o_reg_addr=0, go to RD.
  - RD: wait one cycle for register-file latency, go to LATCH.
  - LATCH: capture i_reg_data into a shift register, byte index=0, go to BYTE.
  - BYTE: when !i_tx_full, write the low byte, shift right 8, byte index+1.
    - After the last byte of a register: if reg index = N_REGS-1, go to EOT (or CHK with feature); else increment reg index and o_reg_addr, go to RD.
  - EOT: when !i_tx_full, write 0x04, go to DONE.
  - DONE: o_done=1. When i_start=0, go to IDLE; a new frame needs a fresh rising level of i_start.
- Back-pressure: while i_tx_full=1 in a write state, o_wr=0, state and indices hold, and the byte is presented again on the next free cycle. No byte is lost or duplicated.
- i_start dropping before DONE: return to IDLE on the next edge, counters cleared, nothing further written.
- Reg index width is NB_ADDR; the terminal compare is against N_REGS-1, so no wrap past the last register.
- Throughput without back-pressure: 2 overhead cycles per register plus one per byte.

Optional Feature:
- Macro: DU_REGS_CHKSUM_EN.
- Defined: state CHK is inserted between the last data byte and EOT.
  - CHK writes one byte equal to the XOR of all data bytes (SOT excluded), cleared at frame start.
  - Frame length is 131 bytes with defaults.
- Not defined: no CHK state and no checksum register; frame as above.

Decomposition:
- Shared package/header du_pkg holds:
  - framing constants ACK 0x05, NAK 0x15, SOT 0x01, EOT 0x04;
  - mode codes CONT 0x01, STEP 0x02;
  - the sender state encoding.
- The same package is used by master, loader and this block.
- One natural sub-module, du_byte_serializer: loads an NB_REG word and emits bytes under a full/ready handshake. It is reused later by a data-memory sender.

Test Plan:
- Register r[i]=0x0403_0201+i×0x0101_0101, steady i_start=1, i_tx_full=0 -> 130 writes, first 0x01, then 01 02 03 04, 02 03 04 05, …, last 0x04; o_done rises the cycle after the EOT write.
- Same stimulus with i_tx_full toggled high on every third cycle -> identical byte sequence, no o_wr while full, o_tx_start == o_wr every cycle.
- i_start held high after done for 10 cycles, then low, then high -> no extra writes while done; second identical frame after the re-rise.
- i_start dropped after 40 bytes -> writes stop within one cycle, o_done stays 0, IDLE reached; next start yields a full frame beginning with 0x01.
- Assert i_rst_n=0 mid-register (byte index 2) -> all outputs 0 immediately (async); after release no writes until i_start.
- With DU_REGS_CHKSUM_EN and all registers 0xA5A5_A5A5 -> checksum byte 0x00 before EOT, 131 bytes; registers r[0]=0x0000_00FF, others 0 -> checksum 0xFF.
